bram_frame_reader: RTL

//  Read-side counterpart of the FMC sample-frame BRAM writer. On each frame IRQ it reads the
//  40-halfword timestamped sample frame (s, ns, PCH0-15, TCH0-15, PT100 x2) from BRAM port B.
//  It packs the halfwords into 32-bit words and emits one AXI4-Stream packet per frame
//  (downstream: DMA / UDP packetizer). Handles backpressure; counts frames and overruns.

---
 rtl/fmc_frame_pkg.sv | 35 +++
 rtl/axis_word_fifo.sv | 51 +++++
 rtl/bram_frame_reader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fmc_frame_pkg.sv
// Shared definitions for the FMC sample-frame BRAM writer and reader:
// frame geometry, halfword offsets, FIFO word type and reader FSM states.
package fmc_frame_pkg;

  localparam int FRAME_HW_DEFAULT = 40;

  // Halfword offsets of each field inside a frame
  localparam int HW_TS_S  = 0;
  localparam int HW_TS_NS = 2;
  localparam int HW_PCH   = 4;
  localparam int HW_TCH   = 20;
  localparam int HW_PT100 = 36;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } frame_word_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  // Even halfword goes to the upper half of the stream word
  function automatic frame_word_t pack_pair(input logic [15:0] hi,
                                            input logic [15:0] lo,
                                            input logic        last);
    frame_word_t w;
    w.last = last;
    w.data = {hi, lo};
    return w;
  endfunction

endpackage

// File: rtl/axis_word_fifo.sv
// Small synchronous FIFO of packed stream words with an occupancy count.
// The head word is presented combinationally so it can drive AXIS directly.
module axis_word_fifo
  import fmc_frame_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  frame_word_t            push_word,
  input  logic                   pop,
  output frame_word_t            head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  frame_word_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: rtl/bram_frame_reader.sv
// Reads one FMC sample frame from BRAM port B per frame IRQ and streams it
// out as one AXI4-Stream packet of packed 32-bit halfword pairs.
module bram_frame_reader
  import fmc_frame_pkg::*;
#(
  parameter int FRAME_HW   = FRAME_HW_DEFAULT,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              frame_irq,
  output logic              bram_clk,
  output logic              bram_rst,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic [1:0]        bram_we,
  output logic [15:0]       bram_din,
  input  logic [15:0]       bram_dout,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       overrun_cnt
);

  localparam int IDX_W = $clog2(FRAME_HW + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = CNT_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_HW - 1);
  localparam logic [CRD_W-1:0] HW_SLOTS  = CRD_W'(2 * FIFO_DEPTH);

  logic [1:0]       rst_pipe;
  logic             rst_n;
  logic             irq_d;
  logic             armed;
  logic             irq_edge;
  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] hw_idx;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]      hi_reg;
  logic             hi_valid;
  logic [CRD_W-1:0] hw_used;
  logic             issue;
  logic             push;
  frame_word_t      push_word;
  logic             pop;
  frame_word_t      head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             tlast_hs;

  assign bram_clk = aclk;
  assign bram_rst = !aresetn;
  assign bram_we  = 2'b00;
  assign bram_din = 16'h0000;

  // Reset asserts asynchronously everywhere but releases on a clock edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // armed masks the first cycle after reset so a level already high is not an edge
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      irq_d <= frame_irq;
      armed <= 1'b1;
    end
  end
  assign irq_edge = frame_irq && !irq_d && armed;

  // Halfwords committed but not yet sent: FIFO words, pack register, read in flight
  assign hw_used  = {1'b0, fifo_count, 1'b0} + CRD_W'(hi_valid) + CRD_W'(rd_valid);
  assign issue    = (state == READ) && (hw_used < HW_SLOTS);
  assign bram_en  = issue;
  assign bram_addr = issue ? (ADDR_W'(BASE_ADDR) + ADDR_W'(hw_idx)) : '0;

  assign pop      = m_axis_tvalid && m_axis_tready;
  assign tlast_hs = pop && m_axis_tlast;
  assign busy     = (state != IDLE);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (irq_edge) state_nxt = READ;
      READ:    if (issue && hw_idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (tlast_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      hw_idx   <= '0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
    end else begin
      if (state == IDLE && irq_edge) hw_idx <= '0;
      else if (issue)                hw_idx <= hw_idx + 1'b1;
      rd_valid <= issue;
      rd_idx   <= hw_idx;
    end
  end

  // Read data arrives one cycle after bram_en; even halfwords wait for their partner
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg   <= '0;
      hi_valid <= 1'b0;
    end else if (rd_valid) begin
      if (!rd_idx[0]) begin
        hi_reg   <= bram_dout;
        hi_valid <= 1'b1;
      end else begin
        hi_valid <= 1'b0;
      end
    end
  end

  assign push      = rd_valid && rd_idx[0];
  assign push_word = pack_pair(hi_reg, bram_dout, rd_idx == LAST_IDX);

  axis_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst_n    (rst_n),
    .push     (push),
    .push_word(push_word),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 32'h0 : head.data;
  assign m_axis_tlast  = !fifo_empty && head.last;

  // Edges while busy, including the tlast cycle, are dropped and counted
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (tlast_hs) frame_cnt <= frame_cnt + 32'd1;
      if (irq_edge && state != IDLE && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

endmodule
